// File: rtl/sequency_reorder.sv
// sequency_reorder
//   Frame reorder buffer for the FWHT output path. Coefficients arrive in
//   natural (Hadamard) order; each frame of N = 2**L_WIDTH coefficients is
//   emitted in sequency order, where output position k reads natural
//   address bitrev(gray(k)). Two ping-pong banks let one frame be written
//   while the previous one is read, with no bubble between frames.
//
// Parameters
//   L_WIDTH  log2 of frame length
//   D_WIDTH  coefficient width
//
// Ports
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset
//   i_valid  input coefficient valid
//   o_ready  buffer can accept a coefficient (register-derived only)
//   i_data   coefficient, natural order, index 0 first
//   o_valid  output coefficient valid
//   i_ready  downstream accepts
//   o_data   coefficient in sequency order
//   o_last   high with position k = N-1
//   o_index  sequency index k of o_data (only with SEQ_REORDER_INDEX_EN)
//
// Build option
//   SEQ_REORDER_INDEX_EN  adds the registered o_index output port.
module sequency_reorder #(
  parameter int L_WIDTH = 3,
  parameter int D_WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [D_WIDTH-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [D_WIDTH-1:0] o_data,
  output logic               o_last
`ifdef SEQ_REORDER_INDEX_EN
  ,
  output logic [L_WIDTH-1:0] o_index
`endif
);

  localparam int N = 2 ** L_WIDTH;
  localparam logic [L_WIDTH-1:0] LAST = '1;

  logic [D_WIDTH-1:0] mem [2][N];

  logic [1:0]         full;
  logic               wr_bank;
  logic               rd_bank;
  logic [L_WIDTH-1:0] wr_cnt;
  logic [L_WIDTH-1:0] rd_cnt;

  logic               wr_fire;
  logic               wr_done;
  logic               advance;
  logic               rd_done;
  logic [1:0]         full_set;
  logic [1:0]         full_clr;

  // Natural-order address of sequency position k: bit-reversed Gray code.
  function automatic logic [L_WIDTH-1:0] seq_addr(input logic [L_WIDTH-1:0] k);
    logic [L_WIDTH-1:0] g;
    g = k ^ (k >> 1);
    return {<<{g}};
  endfunction

  assign o_ready = !full[wr_bank];

  always_comb begin
    wr_fire  = i_valid && o_ready;
    wr_done  = wr_fire && (wr_cnt == LAST);
    advance  = full[rd_bank] && (!o_valid || i_ready);
    rd_done  = advance && (rd_cnt == LAST);
    full_set = '0;
    full_clr = '0;
    if (wr_done) full_set[wr_bank] = 1'b1;
    if (rd_done) full_clr[rd_bank] = 1'b1;
  end

  // Storage is deliberately not reset; stale contents are never read
  // because the full flags gate every fetch.
  always_ff @(posedge i_clk) begin
    if (!i_reset && wr_fire) begin
      mem[wr_bank][wr_cnt] <= i_data;
    end
  end

  // Write side and bank occupancy. Set and clear always target different
  // banks (a write needs its bank not full), so both apply in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      full <= (full & ~full_clr) | full_set;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_done) begin
          wr_bank <= ~wr_bank;
        end
      end
    end
  end

  // Read side: the output register is the only stage, so a bank is freed
  // as soon as its last element has been loaded into it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
`ifdef SEQ_REORDER_INDEX_EN
      o_index <= '0;
`endif
    end else begin
      if (advance) begin
        o_data  <= mem[rd_bank][seq_addr(rd_cnt)];
        o_valid <= 1'b1;
        o_last  <= (rd_cnt == LAST);
`ifdef SEQ_REORDER_INDEX_EN
        o_index <= rd_cnt;
`endif
        rd_cnt  <= rd_cnt + 1'b1;
        if (rd_done) begin
          rd_bank <= ~rd_bank;
        end
      end else if (i_ready && o_valid) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sequency_reorder.sv
// tb_sequency_reorder
//   Self-checking bench for sequency_reorder (L_WIDTH=3, D_WIDTH=16).
//   A negedge monitor keeps a frame-level reference model: accepted inputs
//   are collected per frame, and each completed frame is pushed to an
//   expected queue in sequency order computed arithmetically. Directed
//   table checks cover the exact timing corner cases.
module tb_sequency_reorder;

  localparam int LW = 3;
  localparam int DW = 16;
  localparam int N  = 8;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_last;
`ifdef SEQ_REORDER_INDEX_EN
  logic [LW-1:0] o_index;
`endif

  sequency_reorder #(.L_WIDTH(LW), .D_WIDTH(DW)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_last  (o_last)
`ifdef SEQ_REORDER_INDEX_EN
    ,
    .o_index (o_index)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sequency position k -> natural index, by plain arithmetic.
  function automatic int seq_pos(input int k);
    int g, r;
    g = k ^ (k / 2);
    r = 0;
    for (int b = 0; b < LW; b++) r = r * 2 + ((g >> b) & 1);
    return r;
  endfunction

  // ---------------- reference model / monitor ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    int            idx;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] part[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge i_clk) begin
    if (i_reset) begin
      expq.delete();
      part.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, prev_data);
        chk("stall_last", o_last, prev_last);
      end
      if (o_valid && i_ready) begin
        if (expq.size() == 0) begin
          chk("extra_output", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("out_data", o_data, e.d);
          chk("out_last", o_last, e.last);
`ifdef SEQ_REORDER_INDEX_EN
          chk("out_index", o_index, e.idx);
`endif
        end
      end
      if (i_valid && o_ready) begin
        part.push_back(i_data);
        if (part.size() == N) begin
          for (int k = 0; k < N; k++) begin
            exp_t e;
            e.d    = part[seq_pos(k)];
            e.last = (k == N - 1);
            e.idx  = k;
            expq.push_back(e);
          end
          part.delete();
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [DW-1:0] d);
    int t;
    i_valid = 1'b1;
    i_data  = d;
    t = 0;
    @(negedge i_clk);
    while (!o_ready && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_ready) chk("send_timeout", o_ready, 1);
    @(posedge i_clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          last;
  } vec_t;

  vec_t tbl[N];
  int   perm[N] = '{0, 4, 6, 2, 3, 7, 5, 1};
  logic rnd_done;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      tbl[i].din  = DW'(i);
      tbl[i].dout = DW'(perm[i]);
      tbl[i].last = (i == N - 1);
    end

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    tick(3);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_last", o_last, 0);
`ifdef SEQ_REORDER_INDEX_EN
    chk("rst_index", o_index, 0);
`endif
    i_reset = 1'b0;
    tick(1);

    // Single frame: first o_valid one edge after the last accept.
    for (int i = 0; i < N; i++) send(tbl[i].din);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("t1_latency_not_yet", o_valid, 0);
    for (int i = 0; i < N; i++) begin
      @(negedge i_clk);
      chk("t1_valid", o_valid, 1);
      chk("t1_data", o_data, tbl[i].dout);
      chk("t1_last", o_last, tbl[i].last);
    end
    @(negedge i_clk);
    chk("t1_idle_after", o_valid, 0);
    tick(2);

    // Three frames back to back: 24 outputs with no gap.
    fork
      begin
        for (int i = 0; i < 3 * N; i++) send(DW'(i));
        i_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge i_clk);
        while (!o_valid && w < 60) begin
          @(negedge i_clk);
          w++;
        end
        for (int i = 0; i < 3 * N; i++) begin
          chk("t2_valid", o_valid, 1);
          chk("t2_data", o_data, DW'((i / N) * N + seq_pos(i % N)));
          if (i != 3 * N - 1) @(negedge i_clk);
        end
      end
    join
    tick(4);

    // Backpressure: both banks fill, o_ready drops, then recovers the cycle
    // after the last fetch of the older frame.
    i_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) send(DW'(100 + i));
    i_valid = 1'b1;
    i_data  = DW'(116);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("t3_ready_low", o_ready, 0);
      chk("t3_hold_valid", o_valid, 1);
      chk("t3_hold_data", o_data, 100);
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    begin
      int e;
      e = 0;
      @(negedge i_clk);
      while (!o_ready && e < 20) begin
        @(negedge i_clk);
        e++;
      end
      chk("t3_ready_return_edges", e, 7);
    end
    @(posedge i_clk);
    #1;
    for (int i = 117; i < 124; i++) send(DW'(i));
    i_valid = 1'b0;
    tick(40);
    chk("t3_drained", expq.size(), 0);

    // Random valid gaps and random downstream backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6 * N; i++) begin
          if ($urandom_range(3) == 0) begin
            i_valid = 1'b0;
            tick(1);
          end
          send(DW'($urandom));
        end
        i_valid  = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          i_ready = ($urandom_range(1) == 1);
          tick(1);
        end
      end
    join
    i_ready = 1'b1;
    tick(40);
    chk("rnd_drained", expq.size(), 0);
    chk("rnd_part_empty", part.size(), 0);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) send(DW'(50 + i));
    i_valid = 1'b0;
    i_reset = 1'b1;
    tick(1);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_last", o_last, 0);
    chk("mid_rst_ready", o_ready, 1);
    tick(1);
    i_reset = 1'b0;
    tick(1);
    for (int i = 0; i < N; i++) send(tbl[i].din);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("t5_latency_not_yet", o_valid, 0);
    for (int i = 0; i < N; i++) begin
      @(negedge i_clk);
      chk("t5_valid", o_valid, 1);
      chk("t5_data", o_data, tbl[i].dout);
      chk("t5_last", o_last, tbl[i].last);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("t5_no_extra", o_valid, 0);
    end
    chk("t5_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
